// File: rtl/bike_heading_ctrl.sv
// bike_heading_ctrl: per-bike steering FSM that latches one turn between ticks and drives delta/orientation.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   tick                  one-cycle movement strobe; commits the pending turn
//   start, halt           begin/restart a round; crash/stop request
//   btn_up/left/down/right raw asynchronous direction buttons
//   delta                 signed per-tick pixel-address offset (0 when not moving)
//   orient                orientation code: heading in RUN, 5 otherwise
//   moving                high in RUN
//   turn_pending          a valid turn is latched and awaiting tick
module bike_heading_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int DELTA_W      = 32,
    parameter int START_ORIENT = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      halt,
    input  logic                      btn_up,
    input  logic                      btn_left,
    input  logic                      btn_down,
    input  logic                      btn_right,
    output logic signed [DELTA_W-1:0] delta,
    output logic        [2:0]         orient,
    output logic                      moving,
    output logic                      turn_pending
);
    typedef enum logic [1:0] {IDLE, RUN, CRASHED} stateType;

    localparam logic [1:0] START_HEAD = 2'(START_ORIENT);
    localparam logic signed [DELTA_W-1:0] D_DOWN  = DELTA_W'(SCREEN_W);
    localparam logic signed [DELTA_W-1:0] D_UP    = -D_DOWN;
    localparam logic signed [DELTA_W-1:0] D_RIGHT = DELTA_W'(1);
    localparam logic signed [DELTA_W-1:0] D_LEFT  = -D_RIGHT;

    stateType   state, stateNext;
    logic [1:0] heading, headingNext;
    logic [1:0] pendDir, pendDirNext;
    logic       pendValid, pendValidNext;
    logic [3:0] syncA, syncB;
    logic [1:0] reqDir;
    logic [1:0] commitHeading;
    logic       reqValid;

    // Bit index equals the direction code: 0 up, 1 left, 2 down, 3 right.
    wire [3:0] btnRaw = {btn_right, btn_down, btn_left, btn_up};

    assign reqDir = syncB[1] ? 2'd1 : syncB[2] ? 2'd2 : syncB[3] ? 2'd3 : 2'd0;

    // Requests are judged against the heading in force after this edge, so a
    // turn queued on a committing tick can never reverse the new heading.
    assign commitHeading = (tick && pendValid) ? pendDir : heading;
    assign reqValid = (syncB != 4'd0) && ((syncB & (syncB - 4'd1)) == 4'd0)
                   && (reqDir != commitHeading) && (reqDir != (commitHeading ^ 2'd2));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            heading   <= START_HEAD;
            pendDir   <= 2'd0;
            pendValid <= 1'b0;
            syncA     <= 4'd0;
            syncB     <= 4'd0;
        end else begin
            state     <= stateNext;
            heading   <= headingNext;
            pendDir   <= pendDirNext;
            pendValid <= pendValidNext;
            syncA     <= btnRaw;
            syncB     <= syncA;
        end
    end

    always_comb begin
        stateNext     = state;
        headingNext   = heading;
        pendDirNext   = pendDir;
        pendValidNext = pendValid;
        case (state)
            RUN: begin
                if (halt) begin
                    stateNext     = CRASHED;
                    pendValidNext = 1'b0;
                end else begin
                    if (tick && pendValid) begin
                        headingNext   = pendDir;
                        pendValidNext = 1'b0;
                    end
                    if (reqValid) begin
                        pendValidNext = 1'b1;
                        pendDirNext   = reqDir;
                    end
                end
            end
            IDLE, CRASHED: begin
                if (start) begin
                    stateNext     = RUN;
                    headingNext   = START_HEAD;
                    pendValidNext = 1'b0;
                end
            end
            default: begin
                stateNext     = IDLE;
                pendValidNext = 1'b0;
            end
        endcase
    end

    always_comb begin
        moving       = state == RUN;
        turn_pending = pendValid;
        orient       = moving ? {1'b0, heading} : 3'd5;
        delta        = !moving ? '0
                     : heading == 2'd0 ? D_UP
                     : heading == 2'd1 ? D_LEFT
                     : heading == 2'd2 ? D_DOWN
                     : D_RIGHT;
    end
endmodule

// File: tb/tb_bike_heading_ctrl.sv
// tb_bike_heading_ctrl: directed self-checking bench for bike_heading_ctrl.
module tb_bike_heading_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_right = 1'b0;
    logic [31:0] delta;
    logic [2:0]  orient;
    logic        moving;
    logic        turn_pending;
    int          nCmp = 0;
    int          nBad = 0;

    bike_heading_ctrl dut (
        .clock(clock), .reset(reset), .tick(tick), .start(start), .halt(halt),
        .btn_up(btn_up), .btn_left(btn_left), .btn_down(btn_down), .btn_right(btn_right),
        .delta(delta), .orient(orient), .moving(moving), .turn_pending(turn_pending)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nBad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setBtn(input logic [3:0] b);
        {btn_right, btn_down, btn_left, btn_up} = b;
    endtask

    task automatic press(input logic [3:0] b, input int n);
        setBtn(b);
        repeat (n) step();
        setBtn(4'b0000);
        step();
        step();
    endtask

    task automatic doTick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic chkOut(input string tag, input logic [2:0] o, input logic [31:0] d,
                          input logic m, input logic p);
        chk({tag, ".orient"}, 32'(orient), 32'(o));
        chk({tag, ".delta"}, delta, d);
        chk({tag, ".moving"}, 32'(moving), 32'(m));
        chk({tag, ".pending"}, 32'(turn_pending), 32'(p));
    endtask

    initial begin
        #2 reset = 1'b1;
        step();
        step();
        chkOut("reset", 3'd5, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chkOut("idle", 3'd5, 32'h0, 1'b0, 1'b0);

        start = 1'b1;
        step();
        start = 1'b0;
        chkOut("start", 3'd3, 32'h00000001, 1'b1, 1'b0);

        btn_up = 1'b1;
        step();
        chk("up_sync1", 32'(turn_pending), 32'd0);
        step();
        chk("up_sync2", 32'(turn_pending), 32'd0);
        step();
        chk("up_latched", 32'(turn_pending), 32'd1);
        btn_up = 1'b0;
        doTick();
        chkOut("turn_up", 3'd0, 32'hFFFFFD80, 1'b1, 1'b0);

        press(4'b1000, 3);
        chk("right_pend", 32'(turn_pending), 32'd1);
        doTick();
        chkOut("turn_right", 3'd3, 32'h00000001, 1'b1, 1'b0);

        btn_left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            doTick();
            chk("rev_pend", 32'(turn_pending), 32'd0);
            chk("rev_orient", 32'(orient), 32'd3);
            step();
        end
        btn_left = 1'b0;
        step();
        step();
        chk("rev_after", 32'(turn_pending), 32'd0);

        setBtn(4'b0001);
        repeat (3) step();
        setBtn(4'b0100);
        repeat (3) step();
        setBtn(4'b0000);
        step();
        step();
        chk("last_pend", 32'(turn_pending), 32'd1);
        doTick();
        chkOut("last_wins", 3'd2, 32'h00000280, 1'b1, 1'b0);

        press(4'b1000, 3);
        doTick();
        chk("back_right", 32'(orient), 32'd3);

        setBtn(4'b0011);
        repeat (5) step();
        chk("multi_pend", 32'(turn_pending), 32'd0);
        setBtn(4'b0000);
        step();
        step();
        chk("multi_after", 32'(turn_pending), 32'd0);
        doTick();
        chk("multi_orient", 32'(orient), 32'd3);

        press(4'b0001, 3);
        chk("halt_pend", 32'(turn_pending), 32'd1);
        halt = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chkOut("halt", 3'd5, 32'h0, 1'b0, 1'b0);
        step();
        halt = 1'b0;
        doTick();
        chkOut("crashed", 3'd5, 32'h0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chkOut("restart", 3'd3, 32'h00000001, 1'b1, 1'b0);

        press(4'b0001, 3);
        chk("pre_reset_pend", 32'(turn_pending), 32'd1);
        #2 reset = 1'b1;
        #1;
        chkOut("async_reset", 3'd5, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        start = 1'b1;
        halt = 1'b1;
        step();
        start = 1'b0;
        halt = 1'b0;
        chkOut("start_over_halt", 3'd3, 32'h00000001, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
